// File: rtl/run_ctrl.sv
// run_ctrl: sequences a processor run. Holds the core in reset for
// RESET_CYCLES cycles, releases it, counts run cycles and ends the run on
// an explicit halt, a PC self-loop or a cycle timeout. All outputs are
// registered.
module run_ctrl #(
    parameter int PC_WIDTH     = 32,
    parameter int RESET_CYCLES = 3,
    parameter int MAX_CYCLES   = 15,
    parameter int LOOP_LIMIT   = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [PC_WIDTH-1:0]  core_pc,
    input  logic                 core_halt,
    output logic                 core_reset,
    output logic                 running,
    output logic                 done,
    output logic [1:0]           status,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int LW = $clog2(LOOP_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RUN,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [LW-1:0]         loop_q, loop_d;
    logic [PC_WIDTH-1:0]   prev_pc_q, prev_pc_d;
    logic                  first_q, first_d;
    logic                  core_reset_q, core_reset_d;
    logic                  running_q, running_d;
    logic                  done_q, done_d;
    logic [1:0]            status_q, status_d;
    logic [CNT_WIDTH-1:0]  cycle_q, cycle_d;

    logic [CNT_WIDTH:0]    cyc_w;
    logic [CNT_WIDTH-1:0]  cyc_sat;
    logic                  pc_match;
    logic                  hit_loop;
    logic                  hit_timeout;

    // Next-state and next-output computation for the run sequencer.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        loop_d       = loop_q;
        prev_pc_d    = prev_pc_q;
        first_d      = first_q;
        core_reset_d = core_reset_q;
        running_d    = running_q;
        done_d       = done_q;
        status_d     = status_q;
        cycle_d      = cycle_q;

        cyc_w       = {1'b0, cycle_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
        cyc_sat     = cyc_w[CNT_WIDTH] ? cycle_q : cyc_w[CNT_WIDTH-1:0];
        // first_q masks the entry cycle so the PC loaded at RUN entry never
        // counts as a repeat.
        pc_match    = !first_q && (core_pc == prev_pc_q);
        // loop_q counts repeats seen so far; with the current repeat the run
        // of equal PCs is loop_q + 2 long.
        hit_loop    = pc_match && ((int'(loop_q) + 2) >= LOOP_LIMIT);
        hit_timeout = (cyc_w == (CNT_WIDTH+1)'(MAX_CYCLES));

        case (state_q)
            IDLE: begin
                core_reset_d = 1'b1;
                if (start) begin
                    state_d  = HOLD;
                    hold_d   = '0;
                    cycle_d  = '0;
                    status_d = '0;
                end
            end
            HOLD: begin
                core_reset_d = 1'b1;
                if (hold_q == HW'(RESET_CYCLES - 1)) begin
                    state_d      = RUN;
                    core_reset_d = 1'b0;
                    running_d    = 1'b1;
                    prev_pc_d    = core_pc;
                    first_d      = 1'b1;
                    loop_d       = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            RUN: begin
                cycle_d   = cyc_sat;
                prev_pc_d = core_pc;
                first_d   = 1'b0;
                if (pc_match) begin
                    loop_d = (int'(loop_q) >= LOOP_LIMIT) ? loop_q : loop_q + LW'(1);
                end else begin
                    loop_d = '0;
                end
                if (core_halt || hit_loop || hit_timeout) begin
                    state_d      = DONE;
                    running_d    = 1'b0;
                    done_d       = 1'b1;
                    core_reset_d = 1'b1;
                    if (core_halt) begin
                        status_d = 2'b01;
                    end else if (hit_loop) begin
                        status_d = 2'b10;
                    end else begin
                        status_d = 2'b11;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d  = HOLD;
                    hold_d   = '0;
                    cycle_d  = '0;
                    status_d = '0;
                    done_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d      = IDLE;
            status_d     = '0;
            done_d       = 1'b0;
            running_d    = 1'b0;
            core_reset_d = 1'b1;
        end
    end

    // State and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            loop_q       <= '0;
            prev_pc_q    <= '0;
            first_q      <= 1'b0;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            status_q     <= '0;
            cycle_q      <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            loop_q       <= loop_d;
            prev_pc_q    <= prev_pc_d;
            first_q      <= first_d;
            core_reset_q <= core_reset_d;
            running_q    <= running_d;
            done_q       <= done_d;
            status_q     <= status_d;
            cycle_q      <= cycle_d;
        end
    end

    assign core_reset  = core_reset_q;
    assign running     = running_q;
    assign done        = done_q;
    assign status      = status_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed bench for run_ctrl. One default-parameter instance
// plus a RESET_CYCLES=1 / MAX_CYCLES=1 instance for the boundary build.
module tb_run_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        start_b;
    logic        abort;
    logic [31:0] core_pc;
    logic        core_halt;

    logic        core_reset, running, done;
    logic [1:0]  status;
    logic [15:0] cycle_count;

    logic        core_reset_b, running_b, done_b;
    logic [1:0]  status_b;
    logic [15:0] cycle_count_b;

    int errors = 0;
    int checks = 0;

    run_ctrl u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .core_pc     (core_pc),
        .core_halt   (core_halt),
        .core_reset  (core_reset),
        .running     (running),
        .done        (done),
        .status      (status),
        .cycle_count (cycle_count)
    );

    run_ctrl #(
        .RESET_CYCLES (1),
        .MAX_CYCLES   (1)
    ) u_bnd (
        .clk         (clk),
        .reset       (reset),
        .start       (start_b),
        .abort       (abort),
        .core_pc     (core_pc),
        .core_halt   (core_halt),
        .core_reset  (core_reset_b),
        .running     (running_b),
        .done        (done_b),
        .status      (status_b),
        .cycle_count (cycle_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the directed sequence is a few hundred cycles long.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
        chk({tag, "_running"},    32'(running),    32'd0);
        chk({tag, "_done"},       32'(done),       32'd0);
        chk({tag, "_status"},     32'(status),     32'd0);
        chk({tag, "_cycle"},      32'(cycle_count), 32'd0);
    endtask

    // Pulse start and walk through the 3-cycle HOLD; returns after RUN entry.
    task automatic start_run(input string tag);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk({tag, "_hold_done"},   32'(done),       32'd0);
        chk({tag, "_hold_status"}, 32'(status),     32'd0);
        chk({tag, "_hold_crst"},   32'(core_reset), 32'd1);
        cyc();
        cyc();
        cyc();
        chk({tag, "_run_crst"}, 32'(core_reset), 32'd0);
        chk({tag, "_run_run"},  32'(running),    32'd1);
    endtask

    logic [31:0] loop_seq [6];
    logic [31:0] halt_seq [5];

    initial begin
        loop_seq = '{32'd0, 32'd4, 32'd8, 32'd8, 32'd8, 32'd8};
        halt_seq = '{32'd0, 32'd4, 32'd4, 32'd4, 32'd4};

        reset     = 1'b0;
        start     = 1'b0;
        start_b   = 1'b0;
        abort     = 1'b0;
        core_pc   = '0;
        core_halt = 1'b0;

        // Reset held low two cycles.
        cyc();
        cyc();
        chk_reset_vals("rst");
        reset = 1'b1;
        cyc();
        chk("idle_crst", 32'(core_reset), 32'd1);

        // Default run ending in timeout; start pulsed mid-HOLD is ignored.
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t1_hold1_crst", 32'(core_reset), 32'd1);
        chk("t1_hold1_run",  32'(running),    32'd0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t1_hold2_crst", 32'(core_reset), 32'd1);
        cyc();
        chk("t1_hold3_crst", 32'(core_reset), 32'd1);
        cyc();
        chk("t1_run_crst", 32'(core_reset), 32'd0);
        chk("t1_run_run",  32'(running),    32'd1);
        chk("t1_run_cyc",  32'(cycle_count), 32'd0);
        for (int i = 0; i < 14; i++) begin
            core_pc = core_pc + 32'd4;
            cyc();
        end
        chk("t1_c14_done", 32'(done),        32'd0);
        chk("t1_c14_cyc",  32'(cycle_count), 32'd14);
        chk("t1_c14_run",  32'(running),     32'd1);
        core_pc = core_pc + 32'd4;
        cyc();
        chk("t1_done",    32'(done),        32'd1);
        chk("t1_status",  32'(status),      32'd3);
        chk("t1_cyc",     32'(cycle_count), 32'd15);
        chk("t1_run0",    32'(running),     32'd0);
        chk("t1_crst",    32'(core_reset),  32'd1);
        core_pc = core_pc + 32'd4;
        cyc();
        chk("t1_hold_done", 32'(done),        32'd1);
        chk("t1_hold_cyc",  32'(cycle_count), 32'd15);

        // PC self-loop: 0,4,8,8,8,8 terminates on the sixth RUN cycle.
        start_run("t2");
        for (int i = 0; i < 5; i++) begin
            core_pc = loop_seq[i];
            cyc();
        end
        chk("t2_c5_done", 32'(done), 32'd0);
        core_pc = loop_seq[5];
        cyc();
        chk("t2_done",   32'(done),        32'd1);
        chk("t2_status", 32'(status),      32'd2);
        chk("t2_cyc",    32'(cycle_count), 32'd6);
        chk("t2_crst",   32'(core_reset),  32'd1);

        // Halt on the same cycle as the loop limit: halt wins.
        start_run("t3");
        for (int i = 0; i < 5; i++) begin
            core_pc   = halt_seq[i];
            core_halt = (i == 4);
            cyc();
        end
        core_halt = 1'b0;
        chk("t3_done",   32'(done),        32'd1);
        chk("t3_status", 32'(status),      32'd1);
        chk("t3_cyc",    32'(cycle_count), 32'd5);

        // Halt on the timeout cycle: halt wins.
        start_run("t4");
        for (int i = 0; i < 15; i++) begin
            core_pc   = 32'h100 + 32'(i) * 32'd4;
            core_halt = (i == 14);
            cyc();
        end
        core_halt = 1'b0;
        chk("t4_done",   32'(done),        32'd1);
        chk("t4_status", 32'(status),      32'd1);
        chk("t4_cyc",    32'(cycle_count), 32'd15);

        // Abort with halt on RUN cycle 7, then a clean rerun.
        start_run("t5");
        for (int i = 0; i < 6; i++) begin
            core_pc = 32'h200 + 32'(i) * 32'd4;
            cyc();
        end
        chk("t5_c6_cyc", 32'(cycle_count), 32'd6);
        abort     = 1'b1;
        core_halt = 1'b1;
        core_pc   = 32'h300;
        cyc();
        abort     = 1'b0;
        core_halt = 1'b0;
        chk("t5_ab_done",   32'(done),       32'd0);
        chk("t5_ab_status", 32'(status),     32'd0);
        chk("t5_ab_run",    32'(running),    32'd0);
        chk("t5_ab_crst",   32'(core_reset), 32'd1);
        cyc();
        chk("t5_idle_crst", 32'(core_reset), 32'd1);
        chk("t5_idle_done", 32'(done),       32'd0);
        start_run("t5r");
        chk("t5r_cyc0", 32'(cycle_count), 32'd0);
        core_pc = 32'h400;
        cyc();
        chk("t5r_cyc1", 32'(cycle_count), 32'd1);

        // Reset mid-RUN.
        core_pc = 32'h404;
        cyc();
        reset = 1'b0;
        cyc();
        chk_reset_vals("rst_run");
        reset = 1'b1;

        // Reset mid-HOLD.
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        chk_reset_vals("rst_hold");
        reset = 1'b1;
        cyc();
        cyc();
        cyc();
        cyc();
        chk("rst_hold_idle_run",  32'(running),    32'd0);
        chk("rst_hold_idle_crst", 32'(core_reset), 32'd1);

        // Boundary build: one HOLD cycle, timeout on the first RUN cycle.
        chk("b_idle_crst", 32'(core_reset_b), 32'd1);
        start_b = 1'b1;
        cyc();
        start_b = 1'b0;
        chk("b_hold_crst", 32'(core_reset_b), 32'd1);
        chk("b_hold_run",  32'(running_b),    32'd0);
        cyc();
        chk("b_run_crst", 32'(core_reset_b),  32'd0);
        chk("b_run_run",  32'(running_b),     32'd1);
        chk("b_run_cyc",  32'(cycle_count_b), 32'd0);
        cyc();
        chk("b_done",     32'(done_b),        32'd1);
        chk("b_status",   32'(status_b),      32'd3);
        chk("b_cyc",      32'(cycle_count_b), 32'd1);
        chk("b_run0",     32'(running_b),     32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
